// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response bus between the fetch unit and memory
// master (fetch unit): drives req/addr, samples gnt and the in-order rvalid/rdata response
// slave (memory): samples req/addr, drives gnt, rvalid, rdata
interface if_fetch_unit_if #(
   parameter int PC_W    = 22,
   parameter int INSTR_W = 32
);
   logic               req;
   logic [PC_W-1:0]    addr;
   logic               gnt;
   logic               rvalid;
   logic [INSTR_W-1:0] rdata;
   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch stage owning the PC, issuing single-outstanding imem requests into an IF/ID buffer
// clk, rst_n (async, active-low); hlt/stall/flush pipeline controls; br_target redirect address
// im: imem bus (master); IF_instr/IF_PC/IF_valid: buffered instruction, zero (NOP) when not valid
module if_fetch_unit #(
   parameter int              PC_W     = 22,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hlt,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    br_target,
   if_fetch_unit_if.master    im,
   output logic [INSTR_W-1:0] IF_instr,
   output logic [PC_W-1:0]    IF_PC,
   output logic               IF_valid
);
   typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;
   state_t             state, state_n;
   logic [PC_W-1:0]    fetch_pc, pc_n, buf_pc;
   logic [INSTR_W-1:0] buf_instr;
   logic               acc, cap;
   // rst_n gates the request so nothing is issued while reset is held
   assign im.req   = rst_n && state == REQ && !hlt;
   assign im.addr  = im.req ? fetch_pc : '0;
   assign acc      = im.req && im.gnt;
   assign IF_valid = state == HOLD;
   assign IF_instr = IF_valid ? buf_instr : '0;
   assign IF_PC    = IF_valid ? buf_pc : '0;
   always_comb begin
      state_n = state;
      pc_n    = fetch_pc;
      cap     = 1'b0;
      case (state)
         REQ: begin
            // an address accepted in the flush cycle still owes a response, which must be drained
            if (flush) begin
               pc_n    = br_target;
               state_n = acc ? DRAIN : REQ;
            end else if (acc) state_n = WAIT;
         end
         WAIT: begin
            if (flush) begin
               pc_n    = br_target;
               state_n = im.rvalid ? REQ : DRAIN;
            end else if (im.rvalid) begin
               cap     = 1'b1;
               pc_n    = fetch_pc + 1'b1;
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_n    = br_target;
               state_n = REQ;
            end else if (!stall && !hlt) state_n = REQ;
         end
         default: begin
            if (flush) pc_n = br_target;
            if (im.rvalid) state_n = REQ;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= REQ;
         fetch_pc  <= RESET_PC;
         buf_instr <= '0;
         buf_pc    <= '0;
      end else begin
         state    <= state_n;
         fetch_pc <= pc_n;
         if (cap) begin
            buf_instr <= im.rdata;
            buf_pc    <= fetch_pc;
         end
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed check of if_fetch_unit against a flag-based fetch model
module tb_if_fetch_unit;
   localparam int PC_W = 22, INSTR_W = 32;
   logic clk = 0, rst_n = 0, rst2_n = 0, hlt = 0, stall = 0, flush = 0, zero = 0;
   logic [PC_W-1:0] br_target = '0, zero_pc = '0;
   logic [INSTR_W-1:0] if_instr, if_instr2;
   logic [PC_W-1:0] if_pc, if_pc2;
   logic if_valid, if_valid2;
   if_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) im(), im2();
   if_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
      .clk(clk), .rst_n(rst_n), .hlt(hlt), .stall(stall), .flush(flush), .br_target(br_target),
      .im(im), .IF_instr(if_instr), .IF_PC(if_pc), .IF_valid(if_valid));
   if_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(22'h3FFFFF)) dut2 (
      .clk(clk), .rst_n(rst2_n), .hlt(zero), .stall(zero), .flush(zero), .br_target(zero_pc),
      .im(im2), .IF_instr(if_instr2), .IF_PC(if_pc2), .IF_valid(if_valid2));
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   // model: PC, one outstanding request (possibly stale), and an optional held instruction
   logic [PC_W-1:0] m_pc = '0, m_bpc = '0, mem_addr = '0;
   logic [INSTR_W-1:0] m_buf = '0;
   bit m_out = 0, m_stale = 0, m_have = 0, mem_pend = 0, gnt_rnd = 0, lat_rnd = 0;
   int mem_cnt = 0, lat = 1;
   logic s_req, s_valid;
   logic [PC_W-1:0] s_addr, s_pc;
   logic [INSTR_W-1:0] s_instr;
   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   function automatic logic [INSTR_W-1:0] word(logic [PC_W-1:0] a);
      return 32'hA500_0000 | 32'(a);
   endfunction
   task automatic step();
      logic e_req, acc, cons;
      im.gnt = gnt_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      im.rvalid = mem_pend && mem_cnt == 0;
      im.rdata = im.rvalid ? word(mem_addr) : INSTR_W'($urandom);
      #1;
      s_req = im.req; s_addr = im.addr; s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
      e_req = !m_out && !m_have && !hlt;
      chk("im_req", 32'(s_req), 32'(e_req));
      chk("im_addr", 32'(s_addr), e_req ? 32'(m_pc) : 0);
      chk("IF_valid", 32'(s_valid), 32'(m_have));
      chk("IF_PC", 32'(s_pc), m_have ? 32'(m_bpc) : 0);
      chk("IF_instr", s_instr, m_have ? m_buf : 0);
      acc = e_req && im.gnt;
      cons = m_have && !stall && !hlt;
      if (flush) begin
         if (im.rvalid) begin m_out = 0; m_stale = 0; end
         else if (m_out) m_stale = 1;
         if (acc) begin m_out = 1; m_stale = 1; end
         m_pc = br_target;
         m_have = 0;
      end else begin
         if (cons) m_have = 0;
         if (im.rvalid) begin
            m_out = 0;
            if (m_stale) m_stale = 0;
            else begin m_have = 1; m_buf = im.rdata; m_bpc = m_pc; m_pc = m_pc + 1'b1; end
         end
         if (acc) begin m_out = 1; m_stale = 0; end
      end
      if (im.rvalid) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (im.req && im.gnt) begin
         chk("single_outstanding", 32'(mem_pend), 0);
         mem_pend = 1;
         mem_addr = im.addr;
         mem_cnt = (lat_rnd ? int'($urandom_range(1, 4)) : lat) - 1;
      end
      @(negedge clk);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      logic [PC_W-1:0] p;
      bit p2;
      logic [PC_W-1:0] a2;
      im.gnt = 1; im.rvalid = 0; im.rdata = '0;
      im2.gnt = 1; im2.rvalid = 0; im2.rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_im_req", 32'(im.req), 0);
      chk("rst_IF_valid", 32'(if_valid), 0);
      chk("rst_IF_instr", if_instr, 0);
      chk("rst_IF_PC", 32'(if_pc), 0);
      @(negedge clk);
      rst_n = 1;
      // 1: back-to-back fetch, 1-cycle memory
      for (int c = 0; c < 9; c++) begin
         step();
         if (c % 3 == 0) begin
            chk("t1_req", 32'(s_req), 1);
            chk("t1_addr", 32'(s_addr), c / 3);
         end else if (c % 3 == 2) begin
            chk("t1_valid", 32'(s_valid), 1);
            chk("t1_pc", 32'(s_pc), c / 3);
            chk("t1_instr", s_instr, 32'hA500_0000 + c / 3);
         end else chk("t1_bubble", 32'(s_valid), 0);
      end
      // 2: stall while holding PC 5
      n = 0;
      while (!(m_have && m_bpc == 5) && n < 30) begin step(); n++; end
      chk("t2_reach_hold5", 32'(m_have && m_bpc == 5), 1);
      stall = 1;
      repeat (4) begin
         step();
         chk("t2_valid", 32'(s_valid), 1);
         chk("t2_pc", 32'(s_pc), 5);
         chk("t2_instr", s_instr, 32'hA500_0005);
         chk("t2_no_req", 32'(s_req), 0);
      end
      stall = 0;
      step();
      step();
      chk("t2_next_req", 32'(s_req), 1);
      chk("t2_next_addr", 32'(s_addr), 6);
      // 3: flush one cycle after accepting PC 8 on a 3-cycle memory
      lat = 3;
      n = 0;
      while (!(m_out && m_pc == 8) && n < 40) begin step(); n++; end
      flush = 1; br_target = 22'h100;
      step();
      flush = 0;
      n = 0;
      do begin step(); chk("t3_drain_no_valid", 32'(s_valid), 0); n++; end while (!s_req && n < 12);
      chk("t3_req", 32'(s_req), 1);
      chk("t3_addr", 32'(s_addr), 32'h100);
      n = 0;
      do begin step(); n++; end while (!s_valid && n < 12);
      chk("t3_valid", 32'(s_valid), 1);
      chk("t3_pc", 32'(s_pc), 32'h100);
      chk("t3_instr", s_instr, 32'hA500_0100);
      // 4: flush in the same cycle the old address is granted
      lat = 2;
      flush = 1; br_target = 22'h20;
      step();
      flush = 0; hlt = 1;
      n = 0;
      while (m_out && n < 10) begin step(); n++; end
      hlt = 0; flush = 1; br_target = 22'h40;
      step();
      chk("t4_req", 32'(s_req), 1);
      chk("t4_addr", 32'(s_addr), 32'h20);
      flush = 0;
      n = 0;
      do begin step(); chk("t4_drain_no_valid", 32'(s_valid), 0); n++; end while (!s_req && n < 12);
      chk("t4_next_addr", 32'(s_addr), 32'h40);
      n = 0;
      do begin step(); n++; end while (!s_valid && n < 12);
      chk("t4_pc", 32'(s_pc), 32'h40);
      // 5: hlt in REQ then hlt in WAIT
      p = m_pc;
      hlt = 1;
      repeat (5) begin step(); chk("t5_hlt_no_req", 32'(s_req), 0); end
      hlt = 0;
      step();
      chk("t5_resume_req", 32'(s_req), 1);
      chk("t5_resume_addr", 32'(s_addr), 32'(p));
      hlt = 1;
      n = 0;
      do begin step(); n++; end while (!s_valid && n < 12);
      chk("t5_capture_pc", 32'(s_pc), 32'(p));
      repeat (3) begin
         step();
         chk("t5_hold_valid", 32'(s_valid), 1);
         chk("t5_hold_pc", 32'(s_pc), 32'(p));
      end
      hlt = 0;
      step();
      step();
      chk("t5_after_valid", 32'(s_valid), 0);
      chk("t5_after_addr", 32'(s_addr), 32'(p + 1'b1));
      // randomized traffic
      gnt_rnd = 1; lat_rnd = 1;
      repeat (3000) begin
         hlt = $urandom_range(0, 7) == 0;
         stall = $urandom_range(0, 3) == 0;
         flush = $urandom_range(0, 15) == 0;
         br_target = PC_W'($urandom);
         step();
      end
      hlt = 0; stall = 0; flush = 0;
      // 6: RESET_PC at the top of the address space, wrap, and reset mid-WAIT
      rst2_n = 1;
      p2 = 0; a2 = '0;
      for (int c = 0; c < 5; c++) begin
         im2.rvalid = p2;
         im2.rdata = word(a2);
         #1;
         if (c == 0) begin
            chk("t6_first_req", 32'(im2.req), 1);
            chk("t6_first_addr", 32'(im2.addr), 32'h3F_FFFF);
         end else if (c == 2) begin
            chk("t6_valid", 32'(if_valid2), 1);
            chk("t6_pc", 32'(if_pc2), 32'h3F_FFFF);
            chk("t6_instr", if_instr2, 32'hA53F_FFFF);
         end else if (c == 3) begin
            chk("t6_wrap_req", 32'(im2.req), 1);
            chk("t6_wrap_addr", 32'(im2.addr), 0);
         end else if (c == 4) chk("t6_wait_no_req", 32'(im2.req), 0);
         p2 = im2.req && im2.gnt;
         a2 = im2.addr;
         if (c < 4) @(negedge clk);
      end
      im2.rvalid = 0;
      rst2_n = 0;
      #1;
      chk("t6_rst_req", 32'(im2.req), 0);
      chk("t6_rst_valid", 32'(if_valid2), 0);
      chk("t6_rst_pc", 32'(if_pc2), 0);
      @(negedge clk);
      rst2_n = 1;
      #1;
      chk("t6_restart_req", 32'(im2.req), 1);
      chk("t6_restart_addr", 32'(im2.addr), 32'h3F_FFFF);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-stage producer that drives the IF/ID pipeline register's IF_instr/IF_PC inputs.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers the returned word until the ID side consumes it.
- Obeys the pipeline stall/hlt/flush controls; on flush, redirects to a branch target and discards any in-flight fetch.

Parameters:
- PC_W, 22, PC/address width (word-addressed).
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  clock, all state on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- hlt  input  1  global halt; freezes consumption and issue of new requests.
- stall  input  1  ID-side stall; buffered instruction not consumed.
- flush  input  1  redirect request; highest priority.
- br_target  input  PC_W  redirect address, sampled when flush=1.
- im_req  output  1  instruction memory request valid.
- im_addr  output  PC_W  request address.
- im_gnt  input  1  memory accepts request this cycle (im_req & im_gnt = accepted).
- im_rvalid  input  1  response valid; one per accepted request, at least 1 cycle after accept, in order.
- im_rdata  input  INSTR_W  response instruction.
- IF_instr  output  INSTR_W  instruction presented to the IF/ID register.
- IF_PC  output  PC_W  PC of IF_instr.
- IF_valid  output  1  IF_instr/IF_PC hold a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, fetch_pc=RESET_PC, buffer cleared.
  - im_req=0, IF_valid=0, IF_instr=0, IF_PC=0.
- Outputs:
  - im_req=1 only in REQ with hlt=0; im_addr=fetch_pc (0 when im_req=0).
  - IF_valid=1 only in HOLD. IF_instr/IF_PC = buffer in HOLD, else 0 (a bubble; 0 is the NOP encoding).
- consume = HOLD & !flush & !stall & !hlt. This is the same condition under which the IF/ID register loads.
- Memory holds at most one outstanding request. A response is never refused: im_rvalid is always absorbed, even under hlt or stall.
- PC increment is fetch_pc+1, modulo 2^PC_W; 2^PC_W-1 wraps to 0.
- State REQ:
  - flush: fetch_pc<=br_target. If im_req&im_gnt that cycle (old address accepted) go DRAIN, else stay REQ.
  - else im_req&im_gnt: go WAIT.
  - else stay REQ. hlt suppresses im_req.
- State WAIT:
  - flush & im_rvalid: discard data, fetch_pc<=br_target, go REQ.
  - flush & !im_rvalid: fetch_pc<=br_target, go DRAIN.
  - im_rvalid: buffer<=im_rdata, buf_pc<=fetch_pc, fetch_pc<=fetch_pc+1, go HOLD.
- State HOLD:
  - flush: buffer dropped, fetch_pc<=br_target, go REQ.
  - consume: go REQ.
  - else hold; buffer and outputs stable.
- State DRAIN: awaiting a stale response.
  - im_rvalid: discard, go REQ.
  - flush additionally overwrites fetch_pc<=br_target; a later flush wins.
- Priority order: reset > flush > hlt/stall. A flush during hlt still redirects.
- Minimum latency: 1-cycle memory with im_gnt tied high gives 3 cycles per instruction (REQ→WAIT→HOLD→consume). Bubbles appear as IF_valid=0 with zero outputs.
- A branch target is not re-flushed if flush stays high for several cycles; each flush cycle reloads br_target.
- Reset mid-operation aborts everything. A response arriving after reset deassertion for a pre-reset request is out of spec; memory is reset in the same domain.

Test Plan:
1. Reset, im_gnt=1, 1-cycle memory returning data=addr|0xA5000000:
   - im_addr sequence 0,1,2.
   - IF_valid pulses carry IF_PC=0,1,2 with IF_instr=0xA5000000,0xA5000001,0xA5000002.
   - 3-cycle spacing.
2. HOLD with PC=5, stall=1 for 4 cycles:
   - IF_instr/IF_PC stay at PC 5's word and no im_req is issued.
   - After stall drops, next im_addr=6.
3. WAIT on PC=8 with 3-cycle memory; flush with br_target=0x100 one cycle after accept:
   - DRAIN discards the PC 8 response and IF_valid stays 0.
   - Next im_addr=0x100, then IF_PC=0x100.
4. Flush and im_gnt in the same REQ cycle (addr 0x20, target 0x40):
   - Response for 0x20 is discarded.
   - Next request addr=0x40.
5. hlt=1 in REQ for 5 cycles: im_req=0 throughout; it resumes at the same fetch_pc. hlt raised in WAIT: response captured into HOLD and held until hlt=0.
6. RESET_PC=0x3FFFFF: first fetch 0x3FFFFF, next im_addr=0 (wrap). Assert rst_n=0 mid-WAIT: outputs immediately zero, fetch restarts at RESET_PC.
